// File: rtl/pit_evt_pkg.sv
// Shared definitions for the PIT event logger: register map, CTRL bit
// positions, FIFO entry layout and the bus-acknowledge state encoding.
package pit_evt_pkg;

  localparam logic [2:0] EVT_CTRL = 3'd0;
  localparam logic [2:0] EVT_STAT = 3'd1;
  localparam logic [2:0] EVT_TSR  = 3'd2;
  localparam logic [2:0] EVT_ESRC = 3'd3;
  localparam logic [2:0] EVT_ETS  = 3'd4;
  localparam logic [2:0] EVT_DROP = 3'd5;
  localparam logic [2:0] EVT_THR  = 3'd6;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IEN    = 1;
  localparam int CTRL_OVF    = 2;
  localparam int CTRL_SRC_LO = 4;
  localparam int CTRL_SRC_HI = 7;
  localparam int CTRL_CLR    = 15;

  typedef struct packed {
    logic [3:0]  src;
    logic [15:0] ts;
  } evt_entry_t;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_ACK  = 1'b1
  } ack_st_e;

endpackage

// File: rtl/pit_evt_fifo.sv
// Synchronous FIFO of event entries with flush; push and pop may coincide
// when full (both succeed) and when empty (push only).
module pit_evt_fifo
  import pit_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  evt_entry_t din,
  output evt_entry_t head,
  output logic [4:0] level,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  evt_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == 5'(DEPTH));
  assign empty   = (cnt_q == 5'd0);
  assign level   = cnt_q;
  assign head    = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push at full still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 5'd1;
        2'b01:   cnt_d = cnt_q - 5'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pit_evt_log.sv
// PIT event logger: timestamps rising edges of PIT rollover flags, queues
// {source mask, timestamp} entries and exposes them over a 16-bit Wishbone slave.
module pit_evt_log
  import pit_evt_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int DEPTH = 8
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [2:0]       wb_adr_i,
  input  logic [15:0]      wb_dat_i,
  output logic [15:0]      wb_dat_o,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  input  logic [N_SRC-1:0] evt_i,
  output logic             irq_o,
  output ack_st_e          dbg_state_o
);

  localparam logic [3:0] SRC_MASK = 4'((1 << N_SRC) - 1);

  // Handshake: a slave access is taken when stb&cyc is seen in IDLE; ack is
  // high for exactly the following cycle, and IDLE is always revisited before
  // the next access, so every ack is separated by at least one low cycle.
  ack_st_e     st_q, st_d;
  logic [15:0] dat_q, dat_d;
  logic        en_q, en_d, ien_q, ien_d, ovf_q, ovf_d;
  logic [3:0]  src_en_q, src_en_d;
  logic [15:0] ts_q, ts_d;
  logic [7:0]  drop_q, drop_d;
  logic [4:0]  thr_q, thr_d;
  logic [3:0]  evt_q, evt_d;
  logic        irq_q, irq_d;

  logic [3:0]  evt_w, rise;
  logic        access, wr, rd, clr, push, pop, drop_evt;
  logic [15:0] rdata;
  evt_entry_t  head, din;
  logic [4:0]  level;
  logic        full, empty;

  assign wb_ack_o    = (st_q == ACK_ACK);
  assign wb_dat_o    = dat_q;
  assign irq_o       = irq_q;
  assign dbg_state_o = st_q;

  always_comb begin
    evt_w = '0;
    evt_w[N_SRC-1:0] = evt_i;
  end

  assign access   = (st_q == ACK_IDLE) & wb_stb_i & wb_cyc_i;
  assign wr       = access & wb_we_i;
  assign rd       = access & ~wb_we_i;
  assign clr      = wr & (wb_adr_i == EVT_CTRL) & wb_dat_i[CTRL_CLR];
  assign rise     = evt_w & ~evt_q & src_en_q;
  assign push     = en_q & (|rise) & ~clr;
  assign pop      = rd & (wb_adr_i == EVT_ETS) & ~empty;
  assign drop_evt = push & full & ~pop;
  assign din      = '{src: rise, ts: ts_q};

  pit_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .push  (push),
    .pop   (pop),
    .flush (clr),
    .din   (din),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      EVT_CTRL: rdata = {8'h00, src_en_q, 1'b0, ovf_q, ien_q, en_q};
      EVT_STAT: rdata = {6'h00, full, empty, 3'h0, level};
      EVT_TSR:  rdata = ts_q;
      EVT_ESRC: rdata = empty ? 16'h0000 : {12'h000, head.src};
      EVT_ETS:  rdata = empty ? 16'h0000 : head.ts;
      EVT_DROP: rdata = {8'h00, drop_q};
      EVT_THR:  rdata = {11'h000, thr_q};
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    dat_d    = '0;
    en_d     = en_q;
    ien_d    = ien_q;
    ovf_d    = ovf_q;
    src_en_d = src_en_q;
    ts_d     = ts_q;
    drop_d   = drop_q;
    thr_d    = thr_q;
    evt_d    = evt_w;

    case (st_q)
      ACK_IDLE: if (access) st_d = ACK_ACK;
      default:  st_d = ACK_IDLE;
    endcase

    if (rd) dat_d = rdata;

    if (en_q) ts_d = ts_q + 16'd1;

    if (wr && wb_adr_i == EVT_CTRL) begin
      en_d     = wb_dat_i[CTRL_EN];
      ien_d    = wb_dat_i[CTRL_IEN];
      src_en_d = wb_dat_i[CTRL_SRC_HI:CTRL_SRC_LO] & SRC_MASK;
      if (wb_dat_i[CTRL_OVF]) ovf_d = 1'b0;
    end
    if (wr && wb_adr_i == EVT_THR) thr_d = wb_dat_i[4:0];

    // A fresh overflow wins over a same-cycle OVF clear; a DROP write wins over a count.
    if (drop_evt) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
    if (wr && wb_adr_i == EVT_DROP) drop_d = '0;

    if (clr) begin
      ts_d   = '0;
      ovf_d  = 1'b0;
      drop_d = '0;
    end

    irq_d = ien_q & (((thr_q != 5'd0) & (level >= thr_q)) | ovf_q);
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      st_q     <= ACK_IDLE;
      dat_q    <= '0;
      en_q     <= 1'b0;
      ien_q    <= 1'b0;
      ovf_q    <= 1'b0;
      src_en_q <= SRC_MASK;
      ts_q     <= '0;
      drop_q   <= '0;
      thr_q    <= 5'd1;
      evt_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      dat_q    <= dat_d;
      en_q     <= en_d;
      ien_q    <= ien_d;
      ovf_q    <= ovf_d;
      src_en_q <= src_en_d;
      ts_q     <= ts_d;
      drop_q   <= drop_d;
      thr_q    <= thr_d;
      evt_q    <= evt_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_pit_evt_log.sv
// Directed bench for pit_evt_log: register reset values, capture, overflow,
// full push/pop, CLR, source gating and IRQ threshold.
module tb_pit_evt_log;
  import pit_evt_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  adr;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        we, stb, cyc, ack;
  logic [3:0]  evt;
  logic        irq;
  ack_st_e     dbg_st;

  int n_vec;
  int n_err;
  logic [15:0] rd;

  pit_evt_log #(.N_SRC(4), .DEPTH(8)) dut (
    .wb_clk      (clk),
    .wb_rst      (rst),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat_i),
    .wb_dat_o    (dat_o),
    .wb_we_i     (we),
    .wb_stb_i    (stb),
    .wb_cyc_i    (cyc),
    .wb_ack_o    (ack),
    .evt_i       (evt),
    .irq_o       (irq),
    .dbg_state_o (dbg_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp_v);
    end
  endtask

  // Returns 1ns after the edge that raised ack, with stb already dropped.
  task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [15:0] wd,
                         output logic [15:0] rdat);
    int n;
    @(negedge clk);
    adr = a; we = w; dat_i = wd; stb = 1'b1; cyc = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    if (!ack) chk("ack_timeout", {15'h0, ack}, 16'h0001);
    rdat = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [15:0] wd);
    logic [15:0] dummy;
    wb_xfer(a, 1'b1, wd, dummy);
  endtask

  task automatic wb_chk(input string tag, input logic [2:0] a, input logic [15:0] exp_v);
    logic [15:0] r;
    wb_xfer(a, 1'b0, 16'h0000, r);
    chk(tag, r, exp_v);
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk); evt = m;
    @(negedge clk); evt = 4'h0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; adr = '0; dat_i = '0; we = 0; stb = 0; cyc = 0; evt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Reset state
    chk("rst_ack",  {15'h0, ack}, 16'h0000);
    chk("rst_dat",  dat_o, 16'h0000);
    chk("rst_irq",  {15'h0, irq}, 16'h0000);
    wb_chk("rst_ctrl", EVT_CTRL, 16'h00F0);
    wb_chk("rst_stat", EVT_STAT, 16'h0100);
    wb_chk("rst_ts",   EVT_TSR,  16'h0000);
    wb_chk("rst_drop", EVT_DROP, 16'h0000);
    wb_chk("rst_thr",  EVT_THR,  16'h0001);
    wb_chk("addr7",    3'd7,     16'h0000);
    wb_chk("empty_src", EVT_ESRC, 16'h0000);
    wb_chk("empty_ets", EVT_ETS,  16'h0000);
    wb_chk("empty_stat", EVT_STAT, 16'h0100);

    // Single capture: EN set at edge E, ts reaches 5 after edge E+5,
    // so a rise sampled at edge E+6 is stamped 0x0005.
    wb_wr(EVT_CTRL, 16'h00F1);
    repeat (5) @(posedge clk);
    #1 evt = 4'h4;
    @(posedge clk);
    #1 evt = 4'h0;
    wb_chk("cap_stat", EVT_STAT, 16'h0001);
    wb_chk("cap_src",  EVT_ESRC, 16'h0004);
    wb_chk("cap_ts",   EVT_ETS,  16'h0005);
    wb_chk("cap_stat_after", EVT_STAT, 16'h0100);

    // Simultaneous sources share one entry
    pulse(4'h9);
    wb_chk("sim_stat", EVT_STAT, 16'h0001);
    wb_chk("sim_src",  EVT_ESRC, 16'h0009);
    wb_xfer(EVT_ETS, 1'b0, 16'h0000, rd);
    wb_chk("sim_stat_after", EVT_STAT, 16'h0100);

    // Overflow: 10 events into 8 slots
    wb_wr(EVT_CTRL, 16'h00F3);
    for (int i = 0; i < 10; i++) pulse(4'h1);
    wb_chk("ovf_stat", EVT_STAT, 16'h0208);
    wb_chk("ovf_ctrl", EVT_CTRL, 16'h00F7);
    wb_chk("ovf_drop", EVT_DROP, 16'h0002);
    chk("ovf_irq", {15'h0, irq}, 16'h0001);
    wb_wr(EVT_CTRL, 16'h00F7);
    wb_chk("ovf_clr_ctrl", EVT_CTRL, 16'h00F3);
    chk("ovf_clr_irq", {15'h0, irq}, 16'h0001);

    // Full FIFO: EVT_TS pop acked on the same edge as a new capture
    repeat (2) @(negedge clk);
    adr = EVT_ETS; we = 1'b0; stb = 1'b1; cyc = 1'b1; evt = 4'h2;
    @(posedge clk); #1;
    chk("pp_ack", {15'h0, ack}, 16'h0001);
    stb = 1'b0; cyc = 1'b0; evt = 4'h0;
    wb_chk("pp_stat", EVT_STAT, 16'h0208);
    wb_chk("pp_drop", EVT_DROP, 16'h0002);
    for (int i = 0; i < 7; i++) wb_xfer(EVT_ETS, 1'b0, 16'h0000, rd);
    wb_chk("pp_tail_stat", EVT_STAT, 16'h0001);
    wb_chk("pp_tail_src",  EVT_ESRC, 16'h0002);

    // CLR: EN=1, IEN=0, SRC_EN=0; the TS read is taken two edges after CLR
    wb_wr(EVT_CTRL, 16'h8001);
    wb_chk("clr_ts",   EVT_TSR,  16'h0001);
    wb_chk("clr_stat", EVT_STAT, 16'h0100);
    wb_chk("clr_ctrl", EVT_CTRL, 16'h0001);
    wb_chk("clr_drop", EVT_DROP, 16'h0000);
    chk("clr_irq", {15'h0, irq}, 16'h0000);

    // Source gating
    wb_wr(EVT_CTRL, 16'h0021);
    pulse(4'h1);
    wb_chk("gate_off_stat", EVT_STAT, 16'h0100);
    pulse(4'h2);
    wb_chk("gate_on_src", EVT_ESRC, 16'h0002);
    wb_xfer(EVT_ETS, 1'b0, 16'h0000, rd);
    wb_chk("gate_pop_stat", EVT_STAT, 16'h0100);

    // Level already high when EN rises: no capture
    wb_wr(EVT_CTRL, 16'h0020);
    @(negedge clk); evt = 4'h2;
    repeat (2) @(posedge clk);
    wb_wr(EVT_CTRL, 16'h0021);
    repeat (3) @(posedge clk);
    wb_chk("held_stat", EVT_STAT, 16'h0100);
    @(negedge clk); evt = 4'h0;
    repeat (2) @(posedge clk);
    wb_chk("held_fall_stat", EVT_STAT, 16'h0100);

    // Threshold IRQ with THR=2
    wb_wr(EVT_THR, 16'h0002);
    wb_wr(EVT_CTRL, 16'h0023);
    pulse(4'h2);
    repeat (2) @(posedge clk); #1;
    chk("thr_below_irq", {15'h0, irq}, 16'h0000);
    pulse(4'h2);
    repeat (2) @(posedge clk); #1;
    chk("thr_at_irq", {15'h0, irq}, 16'h0001);
    wb_wr(EVT_THR, 16'h0000);
    repeat (2) @(posedge clk); #1;
    chk("thr_zero_irq", {15'h0, irq}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
